vec_lane_collector: RTL and testbench



---
 rtl/vec_pkg.sv | 26 ++
 rtl/vec_chunk_merge.sv | 38 +++
 rtl/vec_lane_collector.sv | 102 ++++++++++
 tb/tb_vec_lane_collector.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vec_pkg.sv
// Shared types and helpers for the vector lane collector.
package vec_pkg;

  typedef enum logic [1:0] {
    SEW8  = 2'd0,
    SEW16 = 2'd1,
    SEW32 = 2'd2,
    SEW64 = 2'd3
  } sew_e;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    WB
  } col_state_e;

  // Bits written per lane result: the element width, capped by the lane chunk width.
  function automatic int unsigned chunk_w(sew_e vsew, int unsigned lane_width);
    int unsigned sew_bits;
    int unsigned lane_bits;
    sew_bits  = 8 << vsew;
    lane_bits = 1 << lane_width;
    return (sew_bits < lane_bits) ? sew_bits : lane_bits;
  endfunction

endpackage

// File: rtl/vec_chunk_merge.sv
// Combinational merge of one lane result into the destination data and byte-enable images.
module vec_chunk_merge #(
  parameter int unsigned VLEN = 128
) (
  input  logic [VLEN-1:0]   data_in,
  input  logic [VLEN/8-1:0] be_in,
  input  logic [63:0]       vd,
  input  logic [9:0]        regi,
  input  logic              res,
  input  logic [3:0]        chunk_bytes,
  output logic [VLEN-1:0]   data_out,
  output logic [VLEN/8-1:0] be_out,
  output logic              ovf
);

  localparam int unsigned NBYTES = VLEN / 8;

  logic [10:0] end_bit;
  logic        fits;

  assign end_bit = {1'b0, regi} + {4'b0, chunk_bytes, 3'b000};
  assign fits    = (regi[2:0] == 3'b000) && (end_bit <= 11'(VLEN));
  assign ovf     = res & ~fits;

  // Byte b is covered when it lies in [regi/8, regi/8 + chunk_bytes).
  always_comb begin
    data_out = data_in;
    be_out   = be_in;
    for (int unsigned b = 0; b < NBYTES; b++) begin
      if (res && fits && (7'(b) >= regi[9:3]) &&
          ((8'(b) - {1'b0, regi[9:3]}) < {4'b0, chunk_bytes})) begin
        data_out[8*b +: 8] = vd[{3'(7'(b) - regi[9:3]), 3'b000} +: 8];
        be_out[b]          = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vec_lane_collector.sv
// Reassembles per-lane ALU results into one VLEN-bit register image for the VRF write port.
module vec_lane_collector
  import vec_pkg::*;
#(
  parameter int unsigned VLEN       = 128,
  parameter int unsigned LANE_WIDTH = 3,
  parameter int unsigned NB_LANES   = 2
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        start,
  input  logic [2:0]                  vsew,
  input  logic [4:0]                  vd_addr,
  input  logic [(64<<NB_LANES)-1:0]   lane_vd,
  input  logic [(10<<NB_LANES)-1:0]   lane_regi,
  input  logic [(1<<NB_LANES)-1:0]    lane_res,
  input  logic                        alu_done,
  output logic                        wb_valid,
  input  logic                        wb_ready,
  output logic [4:0]                  wb_addr,
  output logic [VLEN-1:0]             wb_data,
  output logic [VLEN/8-1:0]           wb_be,
  output logic                        busy,
  output logic                        overflow
);

  localparam int unsigned NL = 1 << NB_LANES;

  col_state_e          state, state_next;
  sew_e                sew_q;
  logic [4:0]          addr_q;
  logic [VLEN-1:0]     data_q;
  logic [VLEN/8-1:0]   be_q;
  logic                ovf_q;
  logic [3:0]          chunk_bytes;

  logic [VLEN-1:0]     chain_data [NL+1];
  logic [VLEN/8-1:0]   chain_be   [NL+1];
  logic [NL-1:0]       lane_ovf;

  assign chunk_bytes   = 4'(chunk_w(sew_q, LANE_WIDTH) >> 3);
  assign chain_data[0] = data_q;
  assign chain_be[0]   = be_q;

  // Lanes merge in ascending order so the highest lane wins on overlap.
  for (genvar i = 0; i < NL; i++) begin : g_lane
    vec_chunk_merge #(.VLEN(VLEN)) u_merge (
      .data_in     (chain_data[i]),
      .be_in       (chain_be[i]),
      .vd          (lane_vd[64*i +: 64]),
      .regi        (lane_regi[10*i +: 10]),
      .res         (lane_res[i]),
      .chunk_bytes (chunk_bytes),
      .data_out    (chain_data[i+1]),
      .be_out      (chain_be[i+1]),
      .ovf         (lane_ovf[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start)    state_next = COLLECT;
      COLLECT: if (alu_done) state_next = WB;
      WB:      if (wb_ready) state_next = IDLE;
      default:               state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      sew_q  <= SEW8;
      addr_q <= '0;
      data_q <= '0;
      be_q   <= '0;
      ovf_q  <= 1'b0;
    end else if (state == IDLE && start) begin
      sew_q  <= (vsew > 3'd3) ? SEW64 : sew_e'(vsew[1:0]);
      addr_q <= vd_addr;
      data_q <= '0;
      be_q   <= '0;
      ovf_q  <= 1'b0;
    end else if (state == COLLECT) begin
      data_q <= chain_data[NL];
      be_q   <= chain_be[NL];
      ovf_q  <= ovf_q | (|lane_ovf);
    end
  end

  assign wb_valid = (state == WB);
  assign busy     = (state != IDLE);
  assign wb_addr  = addr_q;
  assign wb_data  = data_q;
  assign wb_be    = be_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_vec_lane_collector.sv
// Randomized scoreboard bench for vec_lane_collector with a byte-level reference model.
module tb_vec_lane_collector;

  localparam int unsigned VLEN = 128;

  typedef struct {
    logic [255:0] vd;
    logic [39:0]  regi;
    logic [3:0]   res;
  } cyc_t;

  typedef struct {
    logic [4:0]   addr;
    logic [127:0] data;
    logic [15:0]  be;
    logic         ovf;
  } exp_t;

  logic         clk = 1'b0;
  logic         resetn, start, alu_done, wb_ready;
  logic [2:0]   vsew;
  logic [4:0]   vd_addr;
  logic [255:0] lane_vd;
  logic [39:0]  lane_regi;
  logic [3:0]   lane_res;
  logic         wb_valid, busy, overflow;
  logic [4:0]   wb_addr;
  logic [127:0] wb_data;
  logic [15:0]  wb_be;

  int total = 0;
  int bad   = 0;
  exp_t sb[$];

  logic [127:0] m_data;
  logic [15:0]  m_be;
  logic         m_ovf;

  always #5 clk = ~clk;

  vec_lane_collector #(.VLEN(128), .LANE_WIDTH(3), .NB_LANES(2)) dut (
    .clk(clk), .resetn(resetn), .start(start), .vsew(vsew), .vd_addr(vd_addr),
    .lane_vd(lane_vd), .lane_regi(lane_regi), .lane_res(lane_res), .alu_done(alu_done),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
    .wb_be(wb_be), .busy(busy), .overflow(overflow)
  );

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Chunk width from the rules: SEW = 8<<min(code,3), capped at the 8-bit lane chunk.
  function automatic int unsigned ref_w(input int unsigned code);
    int unsigned s;
    s = (code > 3) ? 3 : code;
    return ((8 << s) < 8) ? (8 << s) : 8;
  endfunction

  task automatic model_write(input logic [63:0] v, input int unsigned r, input int unsigned w);
    if ((r % 8 == 0) && (r + w <= VLEN)) begin
      for (int unsigned k = 0; k < w / 8; k++) begin
        m_data[r + 8*k +: 8] = v[8*k +: 8];
        m_be[r/8 + k]        = 1'b1;
      end
    end else begin
      m_ovf = 1'b1;
    end
  endtask

  task automatic run_txn(input cyc_t cyc[$], input int unsigned code,
                         input logic [4:0] addr, input int unsigned stall);
    int unsigned w;
    exp_t e;
    w       = ref_w(code);
    start   = 1'b1;
    vsew    = 3'(code);
    vd_addr = addr;
    m_data  = '0;
    m_be    = '0;
    m_ovf   = 1'b0;
    step();
    start = 1'b0;
    check("busy_after_start", 160'(busy), 160'(1));
    for (int t = 0; t < cyc.size(); t++) begin
      lane_vd   = cyc[t].vd;
      lane_regi = cyc[t].regi;
      lane_res  = cyc[t].res;
      alu_done  = (t == cyc.size() - 1);
      start     = ($urandom_range(0, 3) == 0);
      vd_addr   = 5'($urandom);
      vsew      = 3'($urandom);
      for (int unsigned i = 0; i < 4; i++)
        if (cyc[t].res[i]) model_write(cyc[t].vd[64*i +: 64], int'(cyc[t].regi[10*i +: 10]), w);
      if (t == cyc.size() - 1) begin
        e.addr = addr; e.data = m_data; e.be = m_be; e.ovf = m_ovf;
        sb.push_back(e);
      end
      step();
    end
    alu_done = 1'b0;
    lane_res = '0;
    start    = 1'b0;
    check("wb_valid_latency", 160'(wb_valid), 160'(1));
    wb_ready = 1'b0;
    for (int unsigned s = 0; s < stall; s++) begin
      start = 1'b1;
      step();
    end
    start    = 1'b0;
    wb_ready = 1'b1;
    step();
    wb_ready = 1'b0;
    check("idle_after_accept", 160'({busy, wb_valid}), 160'(0));
  endtask

  // Monitor: checks stability while stalled and pops the scoreboard on each handshake.
  logic [149:0] held_img;
  logic         held = 1'b0;
  always @(negedge clk) begin
    if (!resetn || !wb_valid) begin
      held <= 1'b0;
    end else begin
      if (held) begin
        check("wb_stable", 160'({wb_data, wb_addr, wb_be, overflow}), 160'(held_img));
      end else begin
        check("wb_expected", 160'(sb.size() != 0), 160'(1));
        held_img = {wb_data, wb_addr, wb_be, overflow};
      end
      held <= 1'b1;
      if (wb_ready) begin
        held <= 1'b0;
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          check("wb_data", 160'(wb_data), 160'(e.data));
          check("wb_be", 160'(wb_be), 160'(e.be));
          check("wb_addr", 160'(wb_addr), 160'(e.addr));
          check("overflow", 160'(overflow), 160'(e.ovf));
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc_t q[$];
    cyc_t c;
    resetn = 1'b0; start = 1'b0; alu_done = 1'b0; wb_ready = 1'b0;
    vsew = '0; vd_addr = '0; lane_vd = '0; lane_regi = '0; lane_res = '0;
    step(); step();
    check("reset_outputs", 160'({wb_valid, busy, overflow, wb_addr, wb_be, wb_data}), 160'(0));
    resetn = 1'b1;
    step();

    // Byte ramp over 4 cycles, all lanes, SEW8.
    q.delete();
    for (int unsigned cy = 0; cy < 4; cy++) begin
      c.vd = '0; c.regi = '0; c.res = 4'hF;
      for (int unsigned i = 0; i < 4; i++) begin
        c.vd[64*i +: 64]   = 64'(4*cy + i);
        c.regi[10*i +: 10] = 10'(8*(4*cy + i));
      end
      q.push_back(c);
    end
    run_txn(q, 0, 5'd3, 0);
    check("ramp_image", 160'(wb_data), 160'(128'h0F0E0D0C0B0A09080706050403020100));

    // SEW32 elements split into byte chunks on lanes 0 and 1.
    q.delete();
    for (int unsigned t = 0; t < 8; t++) begin
      c.vd = '0; c.regi = '0; c.res = 4'b0011;
      for (int unsigned i = 0; i < 2; i++) begin
        c.vd[64*i +: 64]   = 64'(8'hA0 + 4*(2*(t >> 2) + i) + (t & 3));
        c.regi[10*i +: 10] = 10'(32*(2*(t >> 2) + i) + 8*(t & 3));
      end
      q.push_back(c);
    end
    run_txn(q, 2, 5'd17, 1);

    // Partial write.
    q.delete();
    c.vd = '0; c.regi = '0; c.res = 4'b0001;
    c.vd[7:0] = 8'h55; c.regi[9:0] = 10'd16;
    q.push_back(c);
    c.res = 4'b0000;
    q.push_back(c);
    run_txn(q, 0, 5'd9, 0);
    check("partial_be", 160'(wb_be), 160'(16'h0004));

    // Out-of-range lane 3 plus overlapping lanes 0/1.
    q.delete();
    c.vd = '0; c.regi = '0; c.res = 4'b1011;
    c.vd[7:0] = 8'h11; c.vd[71:64] = 8'h22; c.vd[199:192] = 8'h77;
    c.regi[9:0] = 10'd0; c.regi[19:10] = 10'd0; c.regi[39:30] = 10'd124;
    q.push_back(c);
    run_txn(q, 7, 5'd30, 0);

    // Long stall with start attempts in WB, then immediate next start.
    q.delete();
    c.vd = {4{64'h0123456789ABCDEF}}; c.regi = {10'd24, 10'd16, 10'd8, 10'd0}; c.res = 4'hF;
    q.push_back(c);
    run_txn(q, 1, 5'd21, 5);
    q.delete();
    c.res = 4'b0000;
    q.push_back(c);
    run_txn(q, 0, 5'd1, 0);

    // Reset in the middle of collection aborts the operation.
    start = 1'b1; vd_addr = 5'd12; vsew = 3'd0;
    step();
    start = 1'b0;
    lane_res = 4'hF; lane_regi = {10'd24, 10'd16, 10'd8, 10'd0}; lane_vd = '1;
    step();
    lane_res = '0;
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    check("reset_abort", 160'({busy, wb_valid, wb_be}), 160'(0));
    alu_done = 1'b1;
    for (int unsigned k = 0; k < 3; k++) begin
      step();
      check("no_wb_after_reset", 160'(wb_valid), 160'(0));
    end
    alu_done = 1'b0;
    step();

    // Random transactions.
    for (int unsigned n = 0; n < 30; n++) begin
      int unsigned ncyc;
      q.delete();
      ncyc = $urandom_range(1, 6);
      for (int unsigned t = 0; t < ncyc; t++) begin
        c.res = 4'($urandom);
        for (int unsigned i = 0; i < 4; i++) begin
          c.vd[64*i +: 64] = {$urandom, $urandom};
          if ($urandom_range(0, 3) != 0) c.regi[10*i +: 10] = 10'(8 * $urandom_range(0, 15));
          else                           c.regi[10*i +: 10] = 10'($urandom_range(0, 1023));
        end
        q.push_back(c);
      end
      run_txn(q, $urandom_range(0, 7), 5'($urandom), $urandom_range(0, 3));
    end

    step();
    check("scoreboard_drained", 160'(sb.size()), 160'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
